minirisc_ctrl_fsm: RTL and testbench

Multi-cycle main control sequencer for the MiniRISC core. Fetches each instruction through a req/ack handshake, decodes its opcode, and issues the `aluop`/`func` codes consumed by the ALU control decoder. It also sequences data-memory accesses, register write-back and PC update. It is the producer side of the aluop/func interface: every code it emits must select exactly one decoder control line, or none when idle.

---
 rtl/minirisc_ctrl_fsm.sv | 157 +++++++++++++++
 tb/tb_minirisc_ctrl_fsm.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/minirisc_ctrl_fsm.sv
// MiniRISC multi-cycle control sequencer: fetch/decode/exec/mem/wb with aluop/func issue.
// Outputs are registered from the next state; pc_inc and pc_branch are same-cycle strobes.
module minirisc_ctrl_fsm #(
   parameter int OPW = 6
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [OPW-1:0] imem_opcode_i,
   input  logic [3:0]     imem_func_i,
   input  logic           imem_ack_i,
   input  logic           dmem_ack_i,
   input  logic           cmp_true_i,
   output logic           imem_req_o,
   output logic           dmem_req_o,
   output logic           dmem_we_o,
   output logic [3:0]     aluop_o,
   output logic [3:0]     func_o,
   output logic           reg_we_o,
   output logic           wb_sel_o,
   output logic           pc_inc_o,
   output logic           pc_branch_o,
   output logic           halted_o,
   output logic           illegal_o
);

   localparam logic [OPW-1:0] OP_RALU = OPW'(0);
   localparam logic [OPW-1:0] OP_IALU = OPW'(1);
   localparam logic [OPW-1:0] OP_LD   = OPW'(2);
   localparam logic [OPW-1:0] OP_ST   = OPW'(3);
   localparam logic [OPW-1:0] OP_BR   = OPW'(4);
   localparam logic [OPW-1:0] OP_JMP  = OPW'(5);
   localparam logic [OPW-1:0] OP_HALT = OPW'(6);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [OPW-1:0] op_q;
   logic [3:0]     fn_q;
   logic           imem_req_q, dmem_req_q, dmem_we_q, reg_we_q, wb_sel_q, halted_q, illegal_q;
   logic [3:0]     aluop_q, func_q;
   logic           fetch_take_s;
   logic           legal_s;

   function automatic logic is_legal(input logic [OPW-1:0] op, input logic [3:0] fn);
      case (op)
         OP_RALU: is_legal = (fn[3] == 1'b0);
         OP_IALU: is_legal = (fn <= 4'd4);
         OP_BR:   is_legal = (fn <= 4'd2);
         OP_LD, OP_ST, OP_JMP, OP_HALT: is_legal = 1'b1;
         default: is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] exec_aluop(input logic [OPW-1:0] op);
      case (op)
         OP_RALU:      exec_aluop = 4'b0001;
         OP_IALU:      exec_aluop = 4'b0010;
         OP_LD, OP_ST: exec_aluop = 4'b0100;
         OP_BR:        exec_aluop = 4'b1000;
         default:      exec_aluop = 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] exec_func(input logic [OPW-1:0] op, input logic [3:0] fn);
      case (op)
         OP_RALU, OP_IALU, OP_BR: exec_func = fn;
         default:                 exec_func = 4'b0000;
      endcase
   endfunction

   // A fetch is only accepted once the request is actually out, so an ack in the reset cycle is dropped.
   assign fetch_take_s = (state_q == S_FETCH) && imem_req_q && imem_ack_i && !rst_i;
   assign legal_s      = is_legal(op_q, fn_q);

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (fetch_take_s) state_d = S_DECODE;
            else              state_d = S_FETCH;
         end
         S_DECODE: begin
            if (!legal_s || (op_q == OP_HALT)) state_d = S_HALT;
            else                               state_d = S_EXEC;
         end
         S_EXEC: begin
            if ((op_q == OP_RALU) || (op_q == OP_IALU)) state_d = S_WB;
            else if ((op_q == OP_LD) || (op_q == OP_ST)) state_d = S_MEM;
            else                                          state_d = S_FETCH;
         end
         S_MEM: begin
            if (!dmem_ack_i)          state_d = S_MEM;
            else if (op_q == OP_LD)   state_d = S_WB;
            else                      state_d = S_FETCH;
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // State, instruction register and registered outputs decoded from the next state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_FETCH;
         op_q       <= '0;
         fn_q       <= 4'd0;
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         aluop_q    <= 4'd0;
         func_q     <= 4'd0;
         reg_we_q   <= 1'b0;
         wb_sel_q   <= 1'b0;
         halted_q   <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (fetch_take_s) begin
            op_q <= imem_opcode_i;
            fn_q <= imem_func_i;
         end
         imem_req_q <= (state_d == S_FETCH);
         dmem_req_q <= (state_d == S_MEM);
         dmem_we_q  <= (state_d == S_MEM) && (op_q == OP_ST);
         aluop_q    <= (state_d == S_EXEC) ? exec_aluop(op_q) :
                       (state_d == S_MEM)  ? 4'b0100 : 4'b0000;
         func_q     <= (state_d == S_EXEC) ? exec_func(op_q, fn_q) : 4'b0000;
         reg_we_q   <= (state_d == S_WB);
         wb_sel_q   <= (state_d == S_WB) && (op_q == OP_LD);
         halted_q   <= (state_d == S_HALT);
         illegal_q  <= illegal_q || ((state_q == S_DECODE) && !legal_s);
      end
   end

   assign imem_req_o  = imem_req_q;
   assign dmem_req_o  = dmem_req_q;
   assign dmem_we_o   = dmem_we_q;
   assign aluop_o     = aluop_q;
   assign func_o      = func_q;
   assign reg_we_o    = reg_we_q;
   assign wb_sel_o    = wb_sel_q;
   assign halted_o    = halted_q;
   assign illegal_o   = illegal_q;
   assign pc_inc_o    = fetch_take_s;
   assign pc_branch_o = (state_q == S_EXEC) && !rst_i &&
                        ((op_q == OP_JMP) || ((op_q == OP_BR) && cmp_true_i));

endmodule

// File: tb/tb_minirisc_ctrl_fsm.sv
// Directed and random-stream checks of the MiniRISC control sequencer, cycle by cycle.
module tb_minirisc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst, iack, dack, cmp;
   logic [5:0] opcode;
   logic [3:0] ifunc;
   logic       imem_req, dmem_req, dmem_we, reg_we, wb_sel, pc_inc, pc_branch, halted, illegal;
   logic [3:0] aluop, func;
   logic [16:0] outs;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   minirisc_ctrl_fsm #(.OPW(6)) dut (
      .clk_i(clk), .rst_i(rst), .imem_opcode_i(opcode), .imem_func_i(ifunc),
      .imem_ack_i(iack), .dmem_ack_i(dack), .cmp_true_i(cmp),
      .imem_req_o(imem_req), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
      .aluop_o(aluop), .func_o(func), .reg_we_o(reg_we), .wb_sel_o(wb_sel),
      .pc_inc_o(pc_inc), .pc_branch_o(pc_branch), .halted_o(halted), .illegal_o(illegal)
   );

   assign outs = {imem_req, dmem_req, dmem_we, aluop, func, reg_we, wb_sel, pc_inc, pc_branch, halted, illegal};

   function automatic logic [16:0] ex(input logic ir, dr, we, input logic [3:0] a, f,
                                      input logic rw, ws, pi, pb, h, il);
      return {ir, dr, we, a, f, rw, ws, pi, pb, h, il};
   endfunction

   task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts in a FETCH cycle with the request out; leaves the bench in the cycle after DECODE.
   task automatic do_fetch(input logic [5:0] op, input logic [3:0] fn);
      opcode = op; ifunc = fn; iack = 1'b1;
      #1;
      chk("fetch_ack", outs, ex(1'b1,1'b0,1'b0,4'd0,4'd0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
      tick();
      iack = 1'b0; opcode = 6'h3f; ifunc = 4'hf;
      #1;
      chk("decode", outs, 17'd0);
      tick();
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [3:0] fn, input logic c, input int waits);
      logic [3:0] ea, ef;
      logic       eb;
      ea = (op == 6'd0) ? 4'b0001 : (op == 6'd1) ? 4'b0010 :
           (op == 6'd2 || op == 6'd3) ? 4'b0100 : (op == 6'd4) ? 4'b1000 : 4'b0000;
      ef = (op == 6'd0 || op == 6'd1 || op == 6'd4) ? fn : 4'd0;
      eb = (op == 6'd5) || (op == 6'd4 && c);
      do_fetch(op, fn);
      cmp = c;
      #1;
      chk("exec", outs, ex(1'b0,1'b0,1'b0,ea,ef,1'b0,1'b0,1'b0,eb,1'b0,1'b0));
      chk("alu_onehot0", 17'($onehot0(aluop)), 17'd1);
      cmp = 1'b0;
      tick();
      if (op == 6'd2 || op == 6'd3) begin
         for (int w = 0; w <= waits; w++) begin
            dack = (w == waits);
            #1;
            chk("mem", outs, ex(1'b0,1'b1,(op == 6'd3),4'b0100,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
            tick();
         end
         dack = 1'b0;
      end
      if (op <= 6'd2) begin
         chk("wb", outs, ex(1'b0,1'b0,1'b0,4'd0,4'd0,1'b1,(op == 6'd2),1'b0,1'b0,1'b0,1'b0));
         tick();
      end
      chk("next_fetch", outs, ex(1'b1,1'b0,1'b0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
   endtask

   task automatic halt_run(input logic [5:0] op, input logic [3:0] fn, input logic ill);
      do_fetch(op, fn);
      chk("halt", outs, ex(1'b0,1'b0,1'b0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b1,ill));
      iack = 1'b1; dack = 1'b1;
      tick();
      chk("halt_hold", outs, ex(1'b0,1'b0,1'b0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b1,ill));
      iack = 1'b0; dack = 1'b0; rst = 1'b1;
      tick();
      chk("halt_rst", outs, 17'd0);
      rst = 1'b0;
      tick();
      chk("halt_restart", outs, ex(1'b1,1'b0,1'b0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] rop;
      logic [3:0] rfn;
      rst = 1'b1; iack = 1'b0; dack = 1'b0; cmp = 1'b0; opcode = 6'd0; ifunc = 4'd0;
      tick();
      tick();
      chk("reset", outs, 17'd0);
      rst = 1'b0;
      #1;
      chk("reset_release", outs, 17'd0);
      tick();
      chk("first_req", outs, ex(1'b1,1'b0,1'b0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
      tick();
      chk("fetch_wait", outs, ex(1'b1,1'b0,1'b0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));

      run_instr(6'd0, 4'd6, 1'b0, 0);
      run_instr(6'd0, 4'd7, 1'b1, 0);
      run_instr(6'd1, 4'd4, 1'b0, 0);
      run_instr(6'd2, 4'd0, 1'b0, 3);
      run_instr(6'd3, 4'd9, 1'b0, 0);
      run_instr(6'd3, 4'd0, 1'b0, 2);
      run_instr(6'd4, 4'd2, 1'b1, 0);
      run_instr(6'd4, 4'd2, 1'b0, 0);
      run_instr(6'd4, 4'd0, 1'b1, 0);
      run_instr(6'd5, 4'd3, 1'b0, 0);

      // reset for two cycles while a load is waiting in MEM
      do_fetch(6'd2, 4'd0);
      tick();
      chk("pre_rst_mem", outs, ex(1'b0,1'b1,1'b0,4'b0100,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
      rst = 1'b1; dack = 1'b1;
      tick();
      chk("rst_mem1", outs, 17'd0);
      tick();
      chk("rst_mem2", outs, 17'd0);
      rst = 1'b0; iack = 1'b1;
      #1;
      chk("rst_cycle_acks", outs, 17'd0);
      tick();
      iack = 1'b0; dack = 1'b0;
      #1;
      chk("after_rst", outs, ex(1'b1,1'b0,1'b0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
      tick();
      chk("after_rst_hold", outs, ex(1'b1,1'b0,1'b0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));

      halt_run(6'd1, 4'd5, 1'b1);
      halt_run(6'd9, 4'd0, 1'b1);
      halt_run(6'd4, 4'd3, 1'b1);
      halt_run(6'd0, 4'd8, 1'b1);
      halt_run(6'd6, 4'd0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rop = 6'($urandom_range(5, 0));
         case (rop)
            6'd0:    rfn = 4'($urandom_range(7, 0));
            6'd1:    rfn = 4'($urandom_range(4, 0));
            6'd4:    rfn = 4'($urandom_range(2, 0));
            default: rfn = 4'($urandom_range(15, 0));
         endcase
         run_instr(rop, rfn, 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
